// File: rtl/spi_ram_burst.sv
// Command-driven single-port RAM behind an SPI slave: address load, write and read with a tx handshake.
// Optional build macro SPI_RAM_AUTO_INC_EN enables pointer auto-increment for burst access.
module spi_ram_burst #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 2 ** ADDR_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH+1:0]   din,
  input  logic                    tx_ready,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    tx_valid,
  output logic                    rd_ovf,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [ADDR_WIDTH-1:0]   rd_addr
);

  localparam int unsigned DW  = DATA_WIDTH;
  localparam int unsigned AW  = ADDR_WIDTH;
  localparam int unsigned AWP = ADDR_WIDTH + 1;

  localparam logic [AWP-1:0] DEPTH_W = AWP'(MEM_DEPTH);

  localparam logic [1:0] OP_LD_WR = 2'b00;
  localparam logic [1:0] OP_WR    = 2'b01;
  localparam logic [1:0] OP_LD_RD = 2'b10;
  localparam logic [1:0] OP_RD    = 2'b11;

  // Loaded addresses beyond the array are folded back into range.
  function automatic logic [AW-1:0] addr_reduce(input logic [AW-1:0] a);
    logic [AWP-1:0] t;
    t = {1'b0, a} % DEPTH_W;
    return t[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    if ({1'b0, a} == DEPTH_W - AWP'(1)) begin
      return '0;
    end
    return a + AW'(1);
  endfunction

  logic [DW-1:0] mem_q [MEM_DEPTH];

  logic [DW-1:0] dout_q, dout_d;
  logic          tx_valid_q, tx_valid_d;
  logic          rd_ovf_q, rd_ovf_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          mem_we_c;
  logic [1:0]    opcode_c;
  logic [DW-1:0] payload_c;
  logic          slot_free_c;

  assign opcode_c    = din[DW+1:DW];
  assign payload_c   = din[DW-1:0];
  // The output slot frees up on the same edge the pending word is consumed.
  assign slot_free_c = !tx_valid_q || tx_ready;

  always_comb begin
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    rd_ovf_d   = rd_ovf_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    mem_we_c   = 1'b0;

    if (tx_valid_q && tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (rx_valid) begin
      case (opcode_c)
        OP_LD_WR: wr_addr_d = addr_reduce(payload_c[AW-1:0]);
        OP_WR: begin
          mem_we_c = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_addr_d = addr_inc(wr_addr_q);
`else
          wr_addr_d = wr_addr_q;
`endif
        end
        OP_LD_RD: rd_addr_d = addr_reduce(payload_c[AW-1:0]);
        OP_RD: begin
          if (slot_free_c) begin
            dout_d     = mem_q[rd_addr_q];
            tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
            rd_addr_d  = addr_inc(rd_addr_q);
`else
            rd_addr_d  = rd_addr_q;
`endif
          end else begin
            rd_ovf_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      rd_ovf_q   <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
    end else begin
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      rd_ovf_q   <= rd_ovf_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Array storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[wr_addr_q] <= payload_c;
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;
  assign rd_ovf   = rd_ovf_q;
  assign wr_addr  = wr_addr_q;
  assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst; expectations follow SPI_RAM_AUTO_INC_EN when defined.
module tb_spi_ram_burst;

  logic       clk;
  logic       rst_n;
  logic       rx_valid;
  logic [9:0] din;
  logic       tx_ready;
  logic [7:0] dout;
  logic       tx_valid;
  logic       rd_ovf;
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  spi_ram_burst dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_valid (rx_valid),
    .din      (din),
    .tx_ready (tx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .rd_ovf   (rd_ovf),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One command cycle; returns #1 after the edge that samples it.
  task automatic send(input logic [1:0] op, input logic [7:0] data, input logic rdy);
    @(negedge clk);
    rx_valid = 1'b1;
    din      = {op, data};
    tx_ready = rdy;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input logic rdy);
    @(negedge clk);
    rx_valid = 1'b0;
    tx_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    din      = '0;
    tx_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_rd_ovf", 32'(rd_ovf), 32'h0);
    chk("rst_wr_addr", 32'(wr_addr), 32'h0);
    chk("rst_rd_addr", 32'(rd_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic write then read
    send(2'b00, 8'h10, 1'b1);
    chk("basic_wr_addr_load", 32'(wr_addr), 32'h10);
    send(2'b01, 8'hA5, 1'b1);
    send(2'b10, 8'h10, 1'b1);
    chk("basic_tx_valid_before", 32'(tx_valid), 32'h0);
    send(2'b11, 8'h00, 1'b1);
    chk("basic_tx_valid", 32'(tx_valid), 32'h1);
    chk("basic_dout", 32'(dout), 32'hA5);
`ifdef SPI_RAM_AUTO_INC_EN
    chk("basic_wr_addr", 32'(wr_addr), 32'h11);
    chk("basic_rd_addr", 32'(rd_addr), 32'h11);
`else
    chk("basic_wr_addr", 32'(wr_addr), 32'h10);
    chk("basic_rd_addr", 32'(rd_addr), 32'h10);
`endif
    idle(1'b1);
    chk("basic_tx_valid_drop", 32'(tx_valid), 32'h0);

    // repeated writes/reads without reloading addresses
    send(2'b00, 8'h20, 1'b1);
    send(2'b01, 8'h01, 1'b1);
    send(2'b01, 8'h02, 1'b1);
    send(2'b10, 8'h20, 1'b1);
    send(2'b11, 8'h00, 1'b1);
`ifdef SPI_RAM_AUTO_INC_EN
    chk("rep_wr_addr", 32'(wr_addr), 32'h22);
    chk("rep_dout1", 32'(dout), 32'h01);
`else
    chk("rep_wr_addr", 32'(wr_addr), 32'h20);
    chk("rep_dout1", 32'(dout), 32'h02);
`endif
    send(2'b11, 8'h00, 1'b1);
    chk("rep_dout2", 32'(dout), 32'h02);
    chk("rep_tx_valid2", 32'(tx_valid), 32'h1);
    idle(1'b1);
    chk("rep_tx_valid_drop", 32'(tx_valid), 32'h0);

    // burst across the top of the array
    send(2'b00, 8'hFE, 1'b1);
    send(2'b01, 8'h11, 1'b1);
    send(2'b01, 8'h22, 1'b1);
    send(2'b01, 8'h33, 1'b1);
    send(2'b10, 8'hFE, 1'b1);
`ifdef SPI_RAM_AUTO_INC_EN
    chk("burst_wr_addr", 32'(wr_addr), 32'h01);
    send(2'b11, 8'h00, 1'b1);
    chk("burst_dout0", 32'(dout), 32'h11);
    send(2'b11, 8'h00, 1'b1);
    chk("burst_dout1", 32'(dout), 32'h22);
    chk("burst_tx_valid1", 32'(tx_valid), 32'h1);
    send(2'b11, 8'h00, 1'b1);
    chk("burst_dout2", 32'(dout), 32'h33);
    chk("burst_tx_valid2", 32'(tx_valid), 32'h1);
    chk("burst_rd_addr", 32'(rd_addr), 32'h01);
`else
    chk("burst_wr_addr", 32'(wr_addr), 32'hFE);
    send(2'b11, 8'h00, 1'b1);
    chk("burst_dout0", 32'(dout), 32'h33);
    send(2'b11, 8'h00, 1'b1);
    chk("burst_dout1", 32'(dout), 32'h33);
    chk("burst_tx_valid1", 32'(tx_valid), 32'h1);
    send(2'b11, 8'h00, 1'b1);
    chk("burst_dout2", 32'(dout), 32'h33);
    chk("burst_tx_valid2", 32'(tx_valid), 32'h1);
    chk("burst_rd_addr", 32'(rd_addr), 32'hFE);
`endif
    idle(1'b1);
    chk("burst_tx_valid_drop", 32'(tx_valid), 32'h0);

    // backpressure and dropped read
    send(2'b00, 8'h40, 1'b1);
    send(2'b01, 8'h5A, 1'b1);
    send(2'b00, 8'h41, 1'b1);
    send(2'b01, 8'h6B, 1'b1);
    send(2'b10, 8'h40, 1'b1);
    send(2'b11, 8'h00, 1'b0);
    chk("bp_dout", 32'(dout), 32'h5A);
    chk("bp_tx_valid", 32'(tx_valid), 32'h1);
    chk("bp_rd_ovf_clear", 32'(rd_ovf), 32'h0);
    send(2'b11, 8'h00, 1'b0);
    chk("bp_dout_hold", 32'(dout), 32'h5A);
    chk("bp_rd_ovf_set", 32'(rd_ovf), 32'h1);
`ifdef SPI_RAM_AUTO_INC_EN
    chk("bp_rd_addr", 32'(rd_addr), 32'h41);
`else
    chk("bp_rd_addr", 32'(rd_addr), 32'h40);
`endif
    idle(1'b0);
    chk("bp_stall_valid", 32'(tx_valid), 32'h1);
    chk("bp_stall_dout", 32'(dout), 32'h5A);
    idle(1'b1);
    chk("bp_release", 32'(tx_valid), 32'h0);

    // pending word survives address load; transfer and read on the same edge
    send(2'b10, 8'h40, 1'b1);
    send(2'b11, 8'h00, 1'b0);
    send(2'b10, 8'h41, 1'b0);
    chk("sim_pending_valid", 32'(tx_valid), 32'h1);
    chk("sim_pending_dout", 32'(dout), 32'h5A);
    send(2'b11, 8'h00, 1'b1);
    chk("sim_tx_valid", 32'(tx_valid), 32'h1);
    chk("sim_dout", 32'(dout), 32'h6B);
    chk("sim_rd_ovf_sticky", 32'(rd_ovf), 32'h1);

    // asynchronous reset between edges with a word pending
    tx_ready = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_tx_valid", 32'(tx_valid), 32'h0);
    chk("arst_rd_ovf", 32'(rd_ovf), 32'h0);
    chk("arst_wr_addr", 32'(wr_addr), 32'h0);
    chk("arst_rd_addr", 32'(rd_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    send(2'b10, 8'h41, 1'b1);
    send(2'b11, 8'h00, 1'b1);
    chk("arst_mem_kept", 32'(dout), 32'h6B);
    idle(1'b1);

    // write followed directly by a read of the same address
    send(2'b10, 8'h50, 1'b1);
    send(2'b00, 8'h50, 1'b1);
    send(2'b01, 8'h77, 1'b1);
    send(2'b11, 8'h00, 1'b1);
    chk("raw_dout", 32'(dout), 32'h77);
    idle(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised successor of the SPI-slave command RAM.
- Sits between the SPI slave shift logic and the system. Accepts command-tagged words on rx_valid and performs address-load, write and read operations on an internal single-port array.
- Added over the previous generation: generic data/address width, address auto-increment for burst access, a tx_valid/tx_ready output handshake with backpressure, and a sticky read-overrun flag.

Parameters:
- DATA_WIDTH, 8, data word width. Constraint: DATA_WIDTH >= ADDR_WIDTH.
- ADDR_WIDTH, 8, address width.
- MEM_DEPTH, 2**ADDR_WIDTH, number of words. Constraint: MEM_DEPTH <= 2**ADDR_WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  din holds a command this cycle.
- din  in  DATA_WIDTH+2  din[DATA_WIDTH+1:DATA_WIDTH] is the opcode; din[DATA_WIDTH-1:0] is the payload.
- tx_ready  in  1  consumer accepts dout this cycle.
- dout  out  DATA_WIDTH  read data.
- tx_valid  out  1  dout valid; held until accepted.
- rd_ovf  out  1  sticky: a read command was dropped under backpressure.
- wr_addr  out  ADDR_WIDTH  current write pointer (debug).
- rd_addr  out  ADDR_WIDTH  current read pointer (debug).

Behaviour:
- Reset (async, rst_n=0): dout=0, tx_valid=0, rd_ovf=0, wr_addr=0, rd_addr=0.
  - Memory contents are not reset.
  - Reset mid-burst or mid-handshake aborts immediately; any pending tx data is lost.
- Commands are sampled only when rx_valid=1. With rx_valid=0, nothing changes except the tx handshake.
- Opcode 00, load write address: wr_addr <= din[ADDR_WIDTH-1:0].
- Opcode 01, write data: mem[wr_addr] <= din[DATA_WIDTH-1:0], then wr_addr advances (see Optional Feature).
- Opcode 10, load read address: rd_addr <= din[ADDR_WIDTH-1:0].
- Opcode 11, read data: payload ignored.
  - If the output slot is free, meaning tx_valid=0 or (tx_valid=1 and tx_ready=1) this cycle: dout <= mem[rd_addr] and tx_valid <= 1 on the next edge (1-cycle latency), then rd_addr advances.
  - Otherwise: the command is dropped, rd_addr is unchanged, rd_ovf <= 1.
- Handshake:
  - A transfer occurs on any edge where tx_valid=1 and tx_ready=1.
  - After a transfer with no new read, tx_valid <= 0.
  - While tx_valid=1 and tx_ready=0, dout and tx_valid are stable.
  - Transfer and new read on the same edge: tx_valid stays 1 and dout takes the new word (back-to-back, no bubble).
- Address wrap: an advancing pointer at MEM_DEPTH-1 wraps to 0.
  - A loaded address >= MEM_DEPTH is reduced modulo MEM_DEPTH at load time.
- Read-after-write to the same address in consecutive cycles returns the new data, since the write completes at the earlier edge.
- Opcodes 00, 01 and 10 do not affect tx_valid or dout. A pending tx word survives address and write commands.
- rd_ovf clears only on reset.

Optional Feature:
- Macro: SPI_RAM_AUTO_INC_EN.
- Defined: after each write (opcode 01), wr_addr increments by 1 with wrap. After each accepted read (opcode 11), rd_addr increments by 1 with wrap. A dropped read does not increment.
- Undefined: wr_addr and rd_addr change only via opcodes 00 and 10. This matches single-address behaviour, so repeated 01 commands overwrite the same word and repeated 11 commands reread it.

Test Plan:
- Basic write/read, defaults, tx_ready=1: load wr addr 0x10, write 0xA5, load rd addr 0x10, read -> the cycle after the read command: tx_valid=1, dout=0xA5; the following cycle tx_valid=0.
- Burst write/read, SPI_RAM_AUTO_INC_EN defined: wr addr 0xFE, write 0x11, 0x22, 0x33 -> mem[0xFE]=0x11, mem[0xFF]=0x22, mem[0x00]=0x33, wr_addr=0x01. Then rd addr 0xFE and three reads -> dout sequence 0x11, 0x22, 0x33 with tx_valid held high throughout, and rd_addr=0x01.
- Backpressure: tx_ready=0, issue a read (returns 0x5A), then a second read -> dout holds 0x5A, rd_ovf=1, rd_addr advanced only once. Raise tx_ready for one cycle -> tx_valid drops.
- Simultaneous transfer and read: tx_valid=1, tx_ready=1, read command in the same cycle -> next cycle tx_valid=1 with dout=mem[rd_addr].
- Async reset mid-burst: assert rst_n=0 between clock edges while tx_valid=1 -> immediately dout=0, tx_valid=0, rd_ovf=0, pointers=0. Memory contents are retained on the next read after re-initialising the address.
- Macro undefined: write 0x01 then 0x02 without reloading the address -> mem[wr_addr]=0x02, wr_addr unchanged. Two reads -> both return 0x02.
